// File: rtl/clb_config_loader.sv
`default_nettype none
// ============================================================================
// clb_config_loader : serializes config words MSB-first onto a CLB config
// chain, holds prgm_b low while loading, then raises GWE after a startup delay.
// Optional macro CFG_CRC_EN adds a trailing CRC-8 check word.   Rev 1.0
// ============================================================================
module clb_config_loader #(
  parameter int WORD_W      = 16,
  parameter int NUM_WORDS   = 4,
  parameter int STARTUP_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prgm_b,
  output logic              config_data_out,
  output logic              shift_en,
  output logic              GWE,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int c_BW = $clog2(WORD_W + 1);
  localparam int c_WW = $clog2(NUM_WORDS + 2);
  localparam int c_SW = $clog2(STARTUP_CYC + 1);
  localparam logic [c_BW-1:0] c_LAST_BIT  = c_BW'(WORD_W - 1);
  localparam logic [c_WW-1:0] c_NUM_WORDS = c_WW'(NUM_WORDS);
  localparam logic [c_SW-1:0] c_LAST_ST   = c_SW'(STARTUP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_SHIFT   = 2'd2,
    S_STARTUP = 2'd3
  } state_t;

  state_t            r_state, w_state;
  // Holds the not-yet-emitted bits of the current word; the MSB goes out on capture.
  logic [WORD_W-2:0] r_shreg, w_shreg;
  logic [c_BW-1:0]   r_bitcnt, w_bitcnt;
  logic [c_WW-1:0]   r_wcnt, w_wcnt;
  logic [c_SW-1:0]   r_stcnt, w_stcnt;
  logic              r_prgm_b, w_prgm_b;
  logic              r_sdo, w_sdo;
  logic              r_shift_en, w_shift_en;
  logic              r_gwe, w_gwe;
  logic              r_busy, w_busy;
  logic              r_done, w_done;

`ifdef CFG_CRC_EN
  logic [7:0]        r_crc, w_crc;
  logic              r_err, w_err;

  // CRC-8, poly 0x07, one bit at a time in the order bits leave the chain.
  function automatic logic [7:0] f_crc_step(input logic [7:0] i_crc, input logic i_bit);
    logic w_fb;
    w_fb = i_crc[7] ^ i_bit;
    return {i_crc[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
  endfunction
`endif

  always_comb begin
    w_state    = r_state;
    w_shreg    = r_shreg;
    w_bitcnt   = r_bitcnt;
    w_wcnt     = r_wcnt;
    w_stcnt    = r_stcnt;
    w_prgm_b   = r_prgm_b;
    w_sdo      = 1'b0;
    w_shift_en = 1'b0;
    w_gwe      = r_gwe;
    w_busy     = r_busy;
    w_done     = r_done;
`ifdef CFG_CRC_EN
    w_crc      = r_crc;
    w_err      = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state  = S_FETCH;
          w_prgm_b = 1'b0;
          w_busy   = 1'b1;
          w_gwe    = 1'b0;
          w_done   = 1'b0;
          w_wcnt   = '0;
`ifdef CFG_CRC_EN
          w_err    = 1'b0;
          w_crc    = '0;
`endif
        end
      end
      S_FETCH: begin
        if (cfg_valid) begin
`ifdef CFG_CRC_EN
          if (r_wcnt == c_NUM_WORDS) begin
            // Trailing check word: compared, never shifted.
            if (cfg_word[7:0] == r_crc) begin
              w_state  = S_STARTUP;
              w_prgm_b = 1'b1;
              w_stcnt  = '0;
            end else begin
              w_state = S_IDLE;
              w_err   = 1'b1;
              w_busy  = 1'b0;
            end
          end else begin
            w_crc      = f_crc_step(r_crc, cfg_word[WORD_W-1]);
`endif
            w_state    = S_SHIFT;
            w_shreg    = cfg_word[WORD_W-2:0];
            w_sdo      = cfg_word[WORD_W-1];
            w_shift_en = 1'b1;
            w_bitcnt   = '0;
            w_wcnt     = r_wcnt + c_WW'(1);
`ifdef CFG_CRC_EN
          end
`endif
        end
      end
      S_SHIFT: begin
        if (r_bitcnt == c_LAST_BIT) begin
`ifdef CFG_CRC_EN
          w_state = S_FETCH;
`else
          if (r_wcnt < c_NUM_WORDS) begin
            w_state = S_FETCH;
          end else begin
            w_state  = S_STARTUP;
            w_prgm_b = 1'b1;
            w_stcnt  = '0;
          end
`endif
        end else begin
          w_bitcnt   = r_bitcnt + c_BW'(1);
          w_shreg    = r_shreg << 1;
          w_sdo      = r_shreg[WORD_W-2];
          w_shift_en = 1'b1;
`ifdef CFG_CRC_EN
          w_crc      = f_crc_step(r_crc, r_shreg[WORD_W-2]);
`endif
        end
      end
      S_STARTUP: begin
        if (r_stcnt == c_LAST_ST) begin
          w_state = S_IDLE;
          w_gwe   = 1'b1;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_stcnt = r_stcnt + c_SW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_wcnt     <= '0;
      r_stcnt    <= '0;
      r_prgm_b   <= 1'b1;
      r_sdo      <= 1'b0;
      r_shift_en <= 1'b0;
      r_gwe      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef CFG_CRC_EN
      r_crc      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_shreg    <= w_shreg;
      r_bitcnt   <= w_bitcnt;
      r_wcnt     <= w_wcnt;
      r_stcnt    <= w_stcnt;
      r_prgm_b   <= w_prgm_b;
      r_sdo      <= w_sdo;
      r_shift_en <= w_shift_en;
      r_gwe      <= w_gwe;
      r_busy     <= w_busy;
      r_done     <= w_done;
`ifdef CFG_CRC_EN
      r_crc      <= w_crc;
      r_err      <= w_err;
`endif
    end
  end

  assign cfg_ready       = (r_state == S_FETCH);
  assign prgm_b          = r_prgm_b;
  assign config_data_out = r_sdo;
  assign shift_en        = r_shift_en;
  assign GWE             = r_gwe;
  assign busy            = r_busy;
  assign done            = r_done;
`ifdef CFG_CRC_EN
  assign err             = r_err;
`else
  assign err             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/clb_config_loader.md
Name: clb_config_loader

Overview:
Configuration front-end placed directly upstream of a SLICEM logic pair / CLB config chain. Accepts parallel configuration words over a valid/ready handshake and serializes them MSB-first onto the chain's serial config input. Drives active-low program (prgm_b) low while loading. Releases the global write enable (GWE) after a programmable startup delay, which hands the fabric over to user mode.

Parameters:
WORD_W, 16, width of each configuration word; must be >= 2, and >= 8 when CFG_CRC_EN is defined
NUM_WORDS, 4, data words per configuration sequence; must be >= 1
STARTUP_CYC, 4, cycles between prgm_b release and GWE assertion; must be >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a configuration sequence
cfg_word  in  WORD_W  configuration word from the upstream source
cfg_valid  in  1  cfg_word is valid
cfg_ready  out  1  loader accepts cfg_word this cycle
prgm_b  out  1  active-low program enable to the logic pair; 0 while loading
config_data_out  out  1  serial config bit to the first LUT's config_data_in
shift_en  out  1  qualifies config_data_out; one bit per cycle when high
GWE  out  1  global write enable; 1 once configuration is complete
busy  out  1  sequence in progress
done  out  1  last sequence completed successfully
err  out  1  CRC mismatch flag; constant 0 without CFG_CRC_EN

Behaviour:
- Reset values: prgm_b=1, config_data_out=0, shift_en=0, GWE=0, cfg_ready=0, busy=0, done=0, err=0. FSM in IDLE; all counters at 0.
- States: IDLE, FETCH, SHIFT, STARTUP. All outputs are registered except cfg_ready, which is 1 exactly in FETCH.
- IDLE: when start=1, the next cycle enters FETCH with prgm_b=0, busy=1, GWE=0, done=0, err=0, and the word counter cleared. start is ignored in every other state.
- FETCH: on cfg_valid & cfg_ready, the loader captures cfg_word into the shift register, increments the word counter and enters SHIFT. While cfg_valid=0 it stays in FETCH, shift_en=0 and there is no timeout.
- SHIFT: lasts exactly WORD_W cycles. Each cycle config_data_out = the current shift-register MSB and shift_en=1. Bit order is MSB first. The first bit appears the cycle after acceptance.
- After the last bit:
  - word counter < NUM_WORDS -> FETCH
  - otherwise -> STARTUP
- STARTUP: prgm_b=1 and shift_en=0. After STARTUP_CYC cycles the loader sets GWE=1, done=1, busy=0 and returns to IDLE.
- GWE and done hold until the next accepted start or reset.
- Latency with cfg_valid held high: start sampled in cycle 0 -> GWE first high in cycle 1 + NUM_WORDS*(WORD_W+1) + STARTUP_CYC. Each gap cycle on cfg_valid adds one cycle.
- cfg_valid asserted outside FETCH has no effect; upstream must hold the word until it is accepted.
- Reset mid-sequence (any state): all outputs take their reset values on the next edge and partial configuration is discarded. A subsequent start restarts from word 0.
- Counters are sized clog2(WORD_W+1) and clog2(NUM_WORDS+2); no wrap-around within a legal sequence.

Optional Feature:
CFG_CRC_EN
- Defined:
  - After the NUM_WORDS data words, FETCH accepts one extra CRC word. That word is not shifted out.
  - Its low 8 bits are compared against a CRC-8 (poly 0x07, init 0x00, MSB-first) computed over every bit shifted out in the sequence.
  - Match -> STARTUP as normal.
  - Mismatch -> err=1, prgm_b stays 0, GWE=0, done=0, busy=0, return to IDLE.
  - err clears on the next accepted start or on reset.
- Not defined: no CRC word and no CRC logic; err is tied to 0.

Test Plan:
1. WORD_W=4, NUM_WORDS=2, STARTUP_CYC=2, words 0xA then 0x3, cfg_valid held high, start in cycle 0 -> config_data_out 1,0,1,0 (cycles 2-5) and 0,0,1,1 (cycles 7-10) with shift_en=1. prgm_b=0 in cycles 1-10 and 1 from cycle 11. GWE=1 and done=1 from cycle 13.
2. Same configuration with cfg_valid low for 3 cycles before word 2 -> shift_en=0 during the gap, bit stream unchanged, GWE first high in cycle 16.
3. start pulsed during SHIFT -> ignored, sequence unaffected. start after done -> next cycle GWE=0, done=0, prgm_b=0, busy=1.
4. reset asserted on the 3rd bit of word 1 -> next cycle all outputs at reset values. A fresh start then produces the full stream of scenario 1 and GWE at the same relative cycle.
5. CFG_CRC_EN, WORD_W=8, NUM_WORDS=1, word 0xA3, CRC word 0x0060 -> GWE=1, err=0. CRC word 0x0061 -> err=1, GWE=0, prgm_b=0, busy=0.
